// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the writeback and register-file slice.
// Provides the data width, register-index width and the ResultSrc encoding
// used by the writeback result mux.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_TGT = 2'b11
    } result_src_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port.
//   clk_i              rising-edge clock
//   rst_ni             synchronous active-low reset, clears every register
//   we_i               write request (valid & regwrite); x0 and reset are
//                      filtered here
//   waddr_i / wdata_i  write index and data
//   raddr1_i/raddr2_i  read indices
//   rdata1_o/rdata2_o  read data, with same-cycle write-through bypass
module regfile_2r1w #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [XLEN-1:0]          wdata_i,
    input  logic [$clog2(NREGS)-1:0] raddr1_i,
    input  logic [$clog2(NREGS)-1:0] raddr2_i,
    output logic [XLEN-1:0]          rdata1_o,
    output logic [XLEN-1:0]          rdata2_o
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_en;

    // Reset suppresses the write, and x0 is hard-wired to zero.
    assign wr_en = rst_ni & we_i & (waddr_i != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads return zero during reset and for x0; a matching in-flight write
    // is forwarded so decode never observes the stale value.
    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (rst_ni) begin
            if (raddr1_i != '0) begin
                rdata1_o = (wr_en && raddr1_i == waddr_i) ? wdata_i : regs_q[raddr1_i];
            end
            if (raddr2_i != '0) begin
                rdata2_o = (wr_en && raddr2_i == waddr_i) ? wdata_i : regs_q[raddr2_i];
            end
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage of the 5-stage RV32I pipeline.
// Selects ResultW from the W-stage pipeline register, writes it into the
// register file, serves the two decode read ports and counts retirements.
//   clk, reset (sync, active-low)
//   ValidW, RegWriteW, ResultSrcW   W-stage control
//   ALUResultW, ReadDataW, PCPlus4W, PCTargetW, RdW   W-stage data
//   A1D, A2D -> RD1D, RD2D          decode read ports
//   ResultW                         selected writeback value
//   InstRetW                        retired-instruction counter
module wb_regfile #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ValidW,
    input  logic                          RegWriteW,
    input  logic [1:0]                    ResultSrcW,
    input  logic [XLEN-1:0]               ALUResultW,
    input  logic [XLEN-1:0]               ReadDataW,
    input  logic [XLEN-1:0]               PCPlus4W,
    input  logic [XLEN-1:0]               PCTargetW,
    input  logic [riscv_pkg::REG_AW-1:0]  RdW,
    input  logic [riscv_pkg::REG_AW-1:0]  A1D,
    input  logic [riscv_pkg::REG_AW-1:0]  A2D,
    output logic [XLEN-1:0]               RD1D,
    output logic [XLEN-1:0]               RD2D,
    output logic [XLEN-1:0]               ResultW,
    output logic [CNT_W-1:0]              InstRetW
);

    import riscv_pkg::*;

    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        ResultW = ALUResultW;
        case (result_src_e'(ResultSrcW))
            RES_ALU: ResultW = ALUResultW;
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            RES_TGT: ResultW = PCTargetW;
            default: ResultW = ALUResultW;
        endcase
    end

    // Any valid instruction retires, including stores and branches;
    // the counter wraps freely.
    always_comb begin
        instret_d = instret_q;
        if (ValidW) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign InstRetW = instret_q;

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clk_i    (clk),
        .rst_ni   (reset),
        .we_i     (ValidW & RegWriteW),
        .waddr_i  (RdW),
        .wdata_i  (ResultW),
        .raddr1_i (A1D),
        .raddr2_i (A2D),
        .rdata1_o (RD1D),
        .rdata2_o (RD2D)
    );

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ValidW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W, PCTargetW;
    logic [4:0]  RdW, A1D, A2D;
    logic [31:0] RD1D, RD2D, ResultW;
    logic [63:0] InstRetW;
    // Narrow-counter instance used for the wrap check
    logic [31:0] RD1D_n, RD2D_n, ResultW_n;
    logic [3:0]  InstRetW_n;

    wb_regfile dut (
        .clk(clk), .reset(reset), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .PCTargetW(PCTargetW), .RdW(RdW), .A1D(A1D), .A2D(A2D),
        .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .InstRetW(InstRetW)
    );

    wb_regfile #(.CNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .ValidW(ValidW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .PCTargetW(PCTargetW), .RdW(RdW), .A1D(A1D), .A2D(A2D),
        .RD1D(RD1D_n), .RD2D(RD2D_n), .ResultW(ResultW_n), .InstRetW(InstRetW_n)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;
    bit          model_valid = 0;

    function automatic logic [31:0] m_result();
        logic [31:0] choices [4];
        choices[0] = ALUResultW;
        choices[1] = ReadDataW;
        choices[2] = PCPlus4W;
        choices[3] = PCTargetW;
        return choices[ResultSrcW];
    endfunction

    function automatic bit m_we();
        return (reset === 1'b1) && (ValidW === 1'b1) && (RegWriteW === 1'b1) && (RdW != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (reset !== 1'b1) return 32'd0;
        if (a == 5'd0) return 32'd0;
        if (m_we() && a == RdW) return m_result();
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_cnt = 64'd0;
            model_valid = 1;
        end else if (model_valid) begin
            if (m_we()) m_regs[RdW] = m_result();
            if (ValidW === 1'b1) m_cnt = m_cnt + 64'd1;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("ResultW",    {32'd0, ResultW},    {32'd0, m_result()});
            check("RD1D",       {32'd0, RD1D},       {32'd0, m_read(A1D)});
            check("RD2D",       {32'd0, RD2D},       {32'd0, m_read(A2D)});
            check("InstRetW",   InstRetW,            m_cnt);
            check("RD1D_n",     {32'd0, RD1D_n},     {32'd0, m_read(A1D)});
            check("RD2D_n",     {32'd0, RD2D_n},     {32'd0, m_read(A2D)});
            check("ResultW_n",  {32'd0, ResultW_n},  {32'd0, m_result()});
            check("InstRetW_n", {60'd0, InstRetW_n}, {60'd0, m_cnt[3:0]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2);
        ValidW = v; RegWriteW = rw; ResultSrcW = src; ALUResultW = alu;
        RdW = rd; A1D = a1; A2D = a2;
        #1;
    endtask

    initial begin
        logic [31:0] mux_exp [4];
        mux_exp[0] = 32'h11; mux_exp[1] = 32'h22; mux_exp[2] = 32'h33; mux_exp[3] = 32'h44;

        reset = 1'b0;
        ReadDataW = '0; PCPlus4W = '0; PCTargetW = '0;
        drive(0, 0, 2'b00, 32'd0, 5'd0, 5'd0, 5'd0);
        tick(); tick();

        // Reset state
        reset = 1'b1;
        drive(0, 0, 2'b00, 32'd0, 5'd0, 5'd5, 5'd31);
        check("rst_rd1", {32'd0, RD1D}, 64'd0);
        check("rst_rd2", {32'd0, RD2D}, 64'd0);
        check("rst_cnt", InstRetW, 64'd0);

        // Basic write with bypass
        drive(1, 1, 2'b00, 32'hDEADBEEF, 5'd5, 5'd5, 5'd31);
        check("bypass_x5", {32'd0, RD1D}, 64'hDEADBEEF);
        tick();
        drive(0, 0, 2'b00, 32'd0, 5'd0, 5'd5, 5'd31);
        check("stored_x5", {32'd0, RD1D}, 64'hDEADBEEF);
        check("cnt_1", InstRetW, 64'd1);

        // Result mux sweep, each value written to x1..x4
        ReadDataW = 32'h22; PCPlus4W = 32'h33; PCTargetW = 32'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 2'(i), 32'h11, 5'(i + 1), 5'd0, 5'd0);
            check("mux_result", {32'd0, ResultW}, {32'd0, mux_exp[i]});
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 2'b00, 32'h11, 5'd0, 5'(i + 1), 5'd0);
            check("mux_stored", {32'd0, RD1D}, {32'd0, mux_exp[i]});
        end
        check("cnt_5", InstRetW, 64'd5);

        // x0 write is dropped but retires
        drive(1, 1, 2'b00, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        check("x0_rd1_wcycle", {32'd0, RD1D}, 64'd0);
        check("x0_rd2_wcycle", {32'd0, RD2D}, 64'd0);
        tick();
        drive(0, 0, 2'b00, 32'd0, 5'd0, 5'd0, 5'd0);
        check("x0_rd1", {32'd0, RD1D}, 64'd0);
        check("cnt_6", InstRetW, 64'd6);

        // Flushed bubble with RegWriteW set
        drive(0, 1, 2'b00, 32'h55, 5'd7, 5'd7, 5'd0);
        check("bubble_no_bypass", {32'd0, RD1D}, 64'd0);
        tick();
        drive(0, 0, 2'b00, 32'h0, 5'd0, 5'd7, 5'd0);
        check("bubble_x7", {32'd0, RD1D}, 64'd0);
        check("bubble_cnt", InstRetW, 64'd6);

        // Dual-port bypass
        drive(1, 1, 2'b00, 32'h1111, 5'd9, 5'd0, 5'd0);
        tick();
        drive(0, 0, 2'b00, 32'h0, 5'd0, 5'd9, 5'd9);
        check("x9_prev_rd1", {32'd0, RD1D}, 64'h1111);
        check("x9_prev_rd2", {32'd0, RD2D}, 64'h1111);
        drive(1, 1, 2'b00, 32'h1234, 5'd9, 5'd9, 5'd9);
        check("dual_bypass_rd1", {32'd0, RD1D}, 64'h1234);
        check("dual_bypass_rd2", {32'd0, RD2D}, 64'h1234);
        tick();

        // Reset mid-operation
        drive(1, 1, 2'b00, 32'hA5A5A5A5, 5'd3, 5'd0, 5'd0);
        tick();
        drive(1, 0, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(0, 0, 2'b00, 32'h0, 5'd0, 5'd3, 5'd0);
        check("x3_set", {32'd0, RD1D}, 64'hA5A5A5A5);
        check("cnt_10", InstRetW, 64'd10);
        reset = 1'b0;
        drive(1, 1, 2'b00, 32'h77, 5'd4, 5'd3, 5'd4);
        tick();
        reset = 1'b1;
        drive(0, 0, 2'b00, 32'h0, 5'd0, 5'd3, 5'd4);
        check("mid_rst_x3", {32'd0, RD1D}, 64'd0);
        check("mid_rst_x4", {32'd0, RD2D}, 64'd0);
        check("mid_rst_cnt", InstRetW, 64'd0);

        // Counter wrap on the 4-bit instance
        drive(1, 0, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0);
        repeat (15) tick();
        drive(0, 0, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0);
        check("cnt4_15", {60'd0, InstRetW_n}, 64'd15);
        drive(1, 0, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(0, 0, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0);
        check("cnt4_wrap", {60'd0, InstRetW_n}, 64'd0);
        check("cnt64_16", InstRetW, 64'd16);

        // Randomized phase
        repeat (3000) begin
            reset      = ($urandom_range(0, 63) != 0);
            ValidW     = 1'($urandom);
            RegWriteW  = 1'($urandom);
            ResultSrcW = 2'($urandom);
            ALUResultW = $urandom;
            ReadDataW  = $urandom;
            PCPlus4W   = $urandom;
            PCTargetW  = $urandom;
            RdW = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            A1D = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            A2D = $urandom_range(0, 3) == 0 ? A1D : 5'($urandom_range(0, 7));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
